// File: rtl/cpu_ex.sv
// Execute stage of the 16-bit WISC pipeline: operand forwarding, ALU/address
// computation, Z/V/N flag register and the EX/MEM pipeline latch.
module cpu_ex #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pcD,
  input  logic [WIDTH-1:0] regAData,
  input  logic [WIDTH-1:0] regBData,
  input  logic [WIDTH-1:0] immEx,
  input  logic [3:0]       regWrite,
  input  logic [6:0]       EXcontrols,
  input  logic [1:0]       MEMcontrols,
  input  logic [1:0]       WBcontrols,
  input  logic [1:0]       fwdA,
  input  logic [1:0]       fwdB,
  input  logic [WIDTH-1:0] fwdDataM,
  input  logic [WIDTH-1:0] fwdDataW,
  input  logic             stall,
  input  logic             flush,
  output logic             zero,
  output logic             overflow,
  output logic             neg,
  output logic [WIDTH-1:0] aluOutM,
  output logic [WIDTH-1:0] storeDataM,
  output logic [3:0]       regWriteM,
  output logic [1:0]       MEMcontrolsM,
  output logic [1:0]       WBcontrolsM,
  output logic             haltM
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW = 4'h8, OP_SW = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
  localparam logic [3:0] OP_PCS = 4'hE, OP_HLT = 4'hF;

  logic [3:0]       opcode;
  logic             aluSrc;
  logic             unusedCtrl;
  logic [WIDTH-1:0] opA, opBf, opB;
  logic [WIDTH-1:0] addRes, subRes, aluRes;
  logic             addOvf, subOvf, satV;
  logic [8:0]       redHi, redLo;
  logic [9:0]       redSum;
  logic [4:0]       nibSum;
  logic [WIDTH-1:0] paddRes;
  logic [31:0]      rorTmp;
  logic             updZ, updVN;

  assign opcode     = EXcontrols[3:0];
  assign aluSrc     = EXcontrols[5];
  // pcSwitch and regDst are consumed by decode/writeback, not here.
  assign unusedCtrl = EXcontrols[6] ^ EXcontrols[4];

  always_comb begin
    case (fwdA)
      2'b01:   opA = fwdDataM;
      2'b10:   opA = fwdDataW;
      default: opA = regAData;
    endcase
    case (fwdB)
      2'b01:   opBf = fwdDataM;
      2'b10:   opBf = fwdDataW;
      default: opBf = regBData;
    endcase
    opB = aluSrc ? immEx : opBf;
  end

  assign addRes = opA + opB;
  assign subRes = opA - opB;
  assign addOvf = (opA[15] == opB[15]) && (addRes[15] != opA[15]);
  assign subOvf = (opA[15] != opB[15]) && (subRes[15] != opA[15]);

  // Byte sums are signed 9-bit, their total needs 10 bits before sign extension.
  assign redHi  = {opA[15], opA[15:8]} + {opB[15], opB[15:8]};
  assign redLo  = {opA[7], opA[7:0]} + {opB[7], opB[7:0]};
  assign redSum = {redHi[8], redHi} + {redLo[8], redLo};
  assign rorTmp = {opA, opA} >> opB[3:0];

  always_comb begin
    paddRes = '0;
    nibSum  = '0;
    for (int i = 0; i < 4; i++) begin
      nibSum = {opA[4*i+3], opA[4*i +: 4]} + {opB[4*i+3], opB[4*i +: 4]};
      if (nibSum[4] != nibSum[3])
        paddRes[4*i +: 4] = nibSum[4] ? 4'h8 : 4'h7;
      else
        paddRes[4*i +: 4] = nibSum[3:0];
    end
  end

  always_comb begin
    aluRes = '0;
    satV   = 1'b0;
    case (opcode)
      OP_ADD: begin
        satV   = addOvf;
        aluRes = addOvf ? (opA[15] ? 16'h8000 : 16'h7FFF) : addRes;
      end
      OP_SUB: begin
        satV   = subOvf;
        aluRes = subOvf ? (opA[15] ? 16'h8000 : 16'h7FFF) : subRes;
      end
      OP_XOR:       aluRes = opA ^ opB;
      OP_RED:       aluRes = {{6{redSum[9]}}, redSum};
      OP_SLL:       aluRes = opA << opB[3:0];
      OP_SRA:       aluRes = $signed(opA) >>> opB[3:0];
      OP_ROR:       aluRes = rorTmp[15:0];
      OP_PADDSB:    aluRes = paddRes;
      OP_LW, OP_SW: aluRes = (opA & 16'hFFFE) + immEx;
      OP_LLB:       aluRes = {opA[15:8], immEx[7:0]};
      OP_LHB:       aluRes = {immEx[7:0], opA[7:0]};
      OP_PCS:       aluRes = pcD;
      default:      aluRes = '0;
    endcase
  end

  assign updVN = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign updZ  = (opcode <= OP_XOR) || (opcode == OP_SLL) || (opcode == OP_SRA) ||
                 (opcode == OP_ROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero         <= 1'b0;
      overflow     <= 1'b0;
      neg          <= 1'b0;
      aluOutM      <= '0;
      storeDataM   <= '0;
      regWriteM    <= '0;
      MEMcontrolsM <= '0;
      WBcontrolsM  <= '0;
      haltM        <= 1'b0;
    end else if (flush) begin
      aluOutM      <= '0;
      storeDataM   <= '0;
      regWriteM    <= '0;
      MEMcontrolsM <= '0;
      WBcontrolsM  <= '0;
      haltM        <= 1'b0;
    end else if (!stall) begin
      aluOutM      <= aluRes;
      storeDataM   <= opBf;
      regWriteM    <= regWrite;
      MEMcontrolsM <= MEMcontrols;
      WBcontrolsM  <= WBcontrols;
      haltM        <= (opcode == OP_HLT);
      if (updZ)
        zero <= (aluRes == '0);
      if (updVN) begin
        overflow <= satV;
        neg      <= aluRes[15];
      end
    end
  end

endmodule
